ps2_transmitter: RTL and testbench

PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

---
 rtl/ps2_transmitter.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command sender.
// It inhibits the clock, sends the start bit, 8 data bits LSB first, odd parity and stop, then checks the device ack.
`default_nettype none

module ps2_transmitter #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 1500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       kclk_in,
   input  logic       kdata_in,
   output logic       kclk_oe,
   output logic       kdata_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INHIBIT = 3'd1,
      S_REQUEST = 3'd2,
      S_SHIFT   = 3'd3,
      S_ACK     = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             kclk_meta_q, kclk_sync_q, kclk_prev_q;
   logic             kdata_meta_q, kdata_sync_q;
   logic [7:0]       din_q, din_d;
   logic             par_q, par_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [3:0]       edge_cnt_q, edge_cnt_d;
   logic             kdata_oe_q, kdata_oe_d;
   logic             done_q, done_d;
   logic             ack_ok_q, ack_ok_d;
   logic             err_q, err_d;
   logic             kclk_fall;
   logic             tmo_active;
   logic             timeout;

   // Synchronizers idle high so reset release never fakes a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kclk_meta_q  <= 1'b1;
         kclk_sync_q  <= 1'b1;
         kclk_prev_q  <= 1'b1;
         kdata_meta_q <= 1'b1;
         kdata_sync_q <= 1'b1;
      end else begin
         kclk_meta_q  <= kclk_in;
         kclk_sync_q  <= kclk_meta_q;
         kclk_prev_q  <= kclk_sync_q;
         kdata_meta_q <= kdata_in;
         kdata_sync_q <= kdata_meta_q;
      end
   end

   assign kclk_fall  = kclk_prev_q & ~kclk_sync_q;
   assign tmo_active = (state_q == S_REQUEST) || (state_q == S_SHIFT) || (state_q == S_ACK);
   assign timeout    = tmo_active && (tmo_cnt_q == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         din_q      <= 8'h00;
         par_q      <= 1'b0;
         inh_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         edge_cnt_q <= 4'd0;
         kdata_oe_q <= 1'b0;
         done_q     <= 1'b0;
         ack_ok_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         din_q      <= din_d;
         par_q      <= par_d;
         inh_cnt_q  <= inh_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         kdata_oe_q <= kdata_oe_d;
         done_q     <= done_d;
         ack_ok_q   <= ack_ok_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      par_d      = par_q;
      inh_cnt_d  = inh_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      edge_cnt_d = edge_cnt_q;
      kdata_oe_d = kdata_oe_q;
      done_d     = 1'b0;
      ack_ok_d   = ack_ok_q;
      err_d      = err_q;

      if (tmo_active && (tmo_cnt_q != TMO_MAX)) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            kdata_oe_d = 1'b0;
            inh_cnt_d  = '0;
            tmo_cnt_d  = '0;
            edge_cnt_d = 4'd0;
            if (start) begin
               din_d    = din;
               par_d    = ~^din;
               ack_ok_d = 1'b0;
               err_d    = 1'b0;
               state_d  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               // Data goes low in the same cycle the clock is released.
               kdata_oe_d = 1'b1;
               tmo_cnt_d  = '0;
               state_d    = S_REQUEST;
            end else begin
               inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
         end
         S_REQUEST: begin
            edge_cnt_d = 4'd0;
            state_d    = S_SHIFT;
         end
         S_SHIFT: begin
            if (kclk_fall) begin
               if (edge_cnt_q != 4'd10) begin
                  edge_cnt_d = edge_cnt_q + 4'd1;
               end
               if (edge_cnt_q < 4'd8) begin
                  kdata_oe_d = ~din_q[edge_cnt_q[2:0]];
               end else if (edge_cnt_q == 4'd8) begin
                  kdata_oe_d = ~par_q;
               end else begin
                  kdata_oe_d = 1'b0;
                  state_d    = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (kclk_fall) begin
               if (!kdata_sync_q) begin
                  ack_ok_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            kdata_oe_d = 1'b0;
            if (kclk_sync_q && kdata_sync_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            kdata_oe_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase

      // Timeout overrides anything a simultaneous clock edge would have done.
      if (timeout) begin
         edge_cnt_d = edge_cnt_q;
         kdata_oe_d = 1'b0;
         ack_ok_d   = 1'b0;
         err_d      = 1'b1;
         done_d     = 1'b1;
         state_d    = S_IDLE;
      end
   end

   assign kclk_oe  = (state_q == S_INHIBIT);
   assign kdata_oe = kdata_oe_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign ack_ok   = ack_ok_q;
   assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a behavioural PS/2 device on the open-drain lines.
`default_nettype none

module tb_ps2_transmitter;

   localparam int INH = 20;
   localparam int TMO = 5000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] din;
   logic       kclk_in, kdata_in;
   logic       kclk_oe, kdata_oe;
   logic       busy, done, ack_ok, err;
   logic       dev_clow, dev_dlow;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int done_run = 0;
   int done_max = 0;
   logic done_ack = 1'b0;
   logic done_err = 1'b0;

   assign kclk_in  = ~(kclk_oe | dev_clow);
   assign kdata_in = ~(kdata_oe | dev_dlow);

   ps2_transmitter #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .din     (din),
      .kclk_in (kclk_in),
      .kdata_in(kdata_in),
      .kclk_oe (kclk_oe),
      .kdata_oe(kdata_oe),
      .busy    (busy),
      .done    (done),
      .ack_ok  (ack_ok),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) begin
         done_cnt = done_cnt + 1;
         done_ack = ack_ok;
         done_err = err;
         done_run = done_run + 1;
         if (done_run > done_max) done_max = done_run;
      end else begin
         done_run = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_xfer(input logic [7:0] d);
      int n;
      start = 1'b1;
      din   = d;
      tick(1);
      start = 1'b0;
      din   = 8'h00;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("flags_cleared", {30'd0, ack_ok, err}, 32'd0);
      n = 0;
      while (kclk_oe && n < 100) begin
         n = n + 1;
         tick(1);
      end
      chk("inhibit_len", n, INH);
      chk("req_kdata_oe", 32'(kdata_oe), 32'd1);
      chk("req_kclk_oe", 32'(kclk_oe), 32'd0);
   endtask

   task automatic dev_run(input bit do_ack, input int inj_k, input int rst_k,
                          output logic [9:0] rx, output bit aborted);
      rx = '0;
      aborted = 1'b0;
      tick(30);
      for (int k = 0; k < 10; k++) begin
         dev_clow = 1'b1;
         tick(10);
         if (k == inj_k) begin
            start = 1'b1;
            din   = 8'h55;
            tick(1);
            start = 1'b0;
            din   = 8'h00;
         end
         if (k == rst_k) begin
            chk("pre_rst_kdata_oe", 32'(kdata_oe), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("rst_kclk_oe", 32'(kclk_oe), 32'd0);
            chk("rst_kdata_oe", 32'(kdata_oe), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            dev_clow = 1'b0;
            tick(3);
            rst_n = 1'b1;
            aborted = 1'b1;
            return;
         end
         tick(89);
         rx[k] = kdata_in;
         dev_clow = 1'b0;
         tick(100);
      end
      if (do_ack) dev_dlow = 1'b1;
      tick(20);
      dev_clow = 1'b1;
      tick(100);
      dev_clow = 1'b0;
      tick(20);
      dev_dlow = 1'b0;
      tick(80);
   endtask

   task automatic check_xfer(input string tag, input logic [9:0] rx, input logic [7:0] exp_d,
                             input logic exp_par, input logic exp_ack, input int prev_done);
      chk({tag, "_data"}, 32'(rx[7:0]), 32'(exp_d));
      chk({tag, "_parity"}, 32'(rx[8]), 32'(exp_par));
      chk({tag, "_stop"}, 32'(rx[9]), 32'd1);
      chk({tag, "_done_cnt"}, done_cnt, prev_done + 1);
      chk({tag, "_done_flags"}, {30'd0, done_ack, done_err}, {30'd0, exp_ack, ~exp_ack});
      chk({tag, "_idle"}, {29'd0, busy, kclk_oe, kdata_oe}, 32'd0);
   endtask

   initial begin
      logic [9:0] rx;
      bit aborted;
      int n;
      int d0;

      rst_n    = 1'b0;
      start    = 1'b0;
      din      = 8'h00;
      dev_clow = 1'b0;
      dev_dlow = 1'b0;
      #23;
      chk("reset_outputs", {26'd0, kclk_oe, kdata_oe, busy, done, ack_ok, err}, 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(2);

      // 0xED, acked: bits 1,0,1,1,0,1,1,1, parity 1
      d0 = done_cnt;
      start_xfer(8'hED);
      dev_run(1'b1, -1, -1, rx, aborted);
      check_xfer("ed", rx, 8'hED, 1'b1, 1'b1, d0);
      tick(10);
      chk("ack_hold", {30'd0, ack_ok, err}, 32'd2);

      // 0xF4 -> parity 0
      d0 = done_cnt;
      start_xfer(8'hF4);
      dev_run(1'b1, -1, -1, rx, aborted);
      check_xfer("f4", rx, 8'hF4, 1'b0, 1'b1, d0);

      // 0x00 -> parity 1
      d0 = done_cnt;
      start_xfer(8'h00);
      dev_run(1'b1, -1, -1, rx, aborted);
      check_xfer("z0", rx, 8'h00, 1'b1, 1'b1, d0);

      // device leaves data high at the ack edge
      d0 = done_cnt;
      start_xfer(8'hA5);
      dev_run(1'b0, -1, -1, rx, aborted);
      check_xfer("nack", rx, 8'hA5, 1'b1, 1'b0, d0);
      tick(10);
      chk("err_hold", {30'd0, ack_ok, err}, 32'd1);

      // device never clocks: done 5000 cycles after REQUEST entry
      d0 = done_cnt;
      start_xfer(8'h12);
      n = 0;
      while (!done && n < 6000) begin
         n = n + 1;
         tick(1);
      end
      chk("timeout_len", n, TMO);
      chk("timeout_flags", {30'd0, ack_ok, err}, 32'd1);
      chk("timeout_lines", {30'd0, kclk_oe, kdata_oe}, 32'd0);
      tick(3);
      chk("timeout_done_cnt", done_cnt, d0 + 1);
      chk("timeout_busy", 32'(busy), 32'd0);

      // start 0x55 during SHIFT of 0xED is ignored
      d0 = done_cnt;
      start_xfer(8'hED);
      dev_run(1'b1, 3, -1, rx, aborted);
      check_xfer("inject", rx, 8'hED, 1'b1, 1'b1, d0);
      tick(50);
      chk("inject_no_restart", 32'(busy), 32'd0);

      // async reset at SHIFT edge 5, then a normal transfer
      d0 = done_cnt;
      start_xfer(8'hED);
      dev_run(1'b1, -1, 4, rx, aborted);
      chk("rst_aborted", 32'(aborted), 32'd1);
      tick(300);
      chk("rst_no_done", done_cnt, d0);
      start_xfer(8'h3C);
      dev_run(1'b1, -1, -1, rx, aborted);
      check_xfer("post_rst", rx, 8'h3C, 1'b1, 1'b1, d0);

      chk("done_width", done_max, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
